// File: rtl/arbiter_pkg.sv
// Shared geometry of the pixel-array grant arbiter and the address-event word
// emitted by the downstream encoder.
package arbiter_pkg;

  localparam int unsigned ROWS         = 4;
  localparam int unsigned COLS         = 4;
  localparam int unsigned x_width      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned y_width      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned AER_TS_WIDTH = 16;
  localparam int unsigned EVT_WIDTH    = AER_TS_WIDTH + x_width + y_width + 1;

  typedef struct packed {
    logic [AER_TS_WIDTH-1:0] ts;
    logic [y_width-1:0]      y;
    logic [x_width-1:0]      x;
    logic                    pol;
  } aer_event_t;

endpackage

// File: rtl/grant_onehot_encoder.sv
// Combinational index encoder for the 2-D grant matrix; also classifies the
// matrix as exactly-one-hot or multi-hot.
module grant_onehot_encoder
  import arbiter_pkg::*;
(
  input  logic [ROWS-1:0][COLS-1:0] gnt,
  output logic [x_width-1:0]        x,
  output logic [y_width-1:0]        y,
  output logic                      onehot,
  output logic                      multi
);

  logic seen;

  // OR-ing indices is exact for a one-hot matrix; multi-hot results are discarded.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    x     = '0;
    y     = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (gnt[r][c]) begin
          multi = multi | seen;
          seen  = 1'b1;
          x     = x | x_width'(r);
          y     = y | y_width'(c);
        end
      end
    end
    onehot = seen & ~multi;
  end

endmodule

// File: rtl/aer_event_encoder.sv
// Encodes new arbiter grants into timestamped address-event words and streams
// them out of a first-word-fall-through FIFO with drop and error accounting.
module aer_event_encoder
  import arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_WIDTH   = AER_TS_WIDTH,
  parameter int unsigned OVF_WIDTH  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  enable_i,
  input  logic [ROWS-1:0][COLS-1:0]             gnt_i,
  input  logic                                  polarity_i,
  input  logic                                  evt_ready_i,
  output logic                                  evt_valid_o,
  output logic [TS_WIDTH+x_width+y_width:0]     evt_data_o,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count_o,
  output logic [OVF_WIDTH-1:0]                  overflow_cnt_o,
  output logic                                  multi_gnt_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WORD_W = TS_WIDTH + x_width + y_width + 1;

  logic [TS_WIDTH-1:0]        ts;
  logic [ROWS-1:0][COLS-1:0]  prev_gnt;
  logic [WORD_W-1:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [OVF_WIDTH-1:0]       ovf_cnt;
  logic                       multi_err;

  logic [x_width-1:0]         gnt_x;
  logic [y_width-1:0]         gnt_y;
  logic                       gnt_onehot;
  logic                       gnt_multi;

  logic                       new_evt;
  logic                       full;
  logic                       push;
  logic                       drop;
  logic                       pop;

  grant_onehot_encoder u_enc (
    .gnt    (gnt_i),
    .x      (gnt_x),
    .y      (gnt_y),
    .onehot (gnt_onehot),
    .multi  (gnt_multi)
  );

  // A held grant only counts once: compare against last cycle's matrix.
  assign new_evt = enable_i & gnt_onehot & (gnt_i != prev_gnt);
  // Full uses the pre-edge count, so a same-cycle pop never makes room.
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign push    = new_evt & ~full;
  assign drop    = new_evt & full;
  assign pop     = evt_valid_o & evt_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts        <= '0;
      prev_gnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_cnt   <= '0;
      multi_err <= 1'b0;
    end else begin
      ts       <= ts + TS_WIDTH'(1);
      prev_gnt <= gnt_i;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_WIDTH'(1);
      if (enable_i && gnt_multi)   multi_err <= 1'b1;
    end
  end

  // Storage needs no reset: the read side is gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem[wr_ptr] <= {ts, gnt_y, gnt_x, polarity_i};
  end

  assign evt_valid_o     = (count != '0);
  assign evt_data_o      = evt_valid_o ? mem[rd_ptr] : '0;
  assign fifo_count_o    = count;
  assign overflow_cnt_o  = ovf_cnt;
  assign multi_gnt_err_o = multi_err;

endmodule
